// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the operand-forwarding hazard controller
package hazard_pkg;
    localparam int REG_ADDR_SIZE = 5;
    localparam logic [REG_ADDR_SIZE-1:0] ZERO_REG = '0;
    typedef struct packed {
        logic                     valid;
        logic [REG_ADDR_SIZE-1:0] rd;
        logic                     reg_write;
        logic                     mem_read;
    } pipe_slot_t;
    localparam pipe_slot_t BUBBLE_SLOT = '0;
endpackage

// File: rtl/hazard_addr_cmp.sv
// hazard_addr_cmp: flags a source operand that is produced by a live, writing slot
//   rs_i    source register address
//   used_i  instruction actually reads rs_i
//   slot_i  in-flight producer slot
//   match_o slot forwards to rs_i (zero register never forwards)
module hazard_addr_cmp
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_SIZE-1:0] rs_i,
    input  logic                     used_i,
    input  pipe_slot_t               slot_i,
    output logic                     match_o
);
    assign match_o = used_i & slot_i.valid & slot_i.reg_write &
                     (slot_i.rd == rs_i) & (rs_i != ZERO_REG);
endmodule

// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl: tracks EXE/MEM producers, registers ALU forwarding selects, stalls on load-use
//   clk, rst (async, active-low)
//   id_*            ID-stage instruction fields; flush kills the ID->EXE transfer
//   rsN_exe_hazard  EXE operand N takes the EXE/MEM result
//   rsN_mem_hazard  EXE operand N takes the MEM/WB result
//   stall           combinational; hold PC and IF/ID, bubble into EXE
module forward_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_ADDR_SIZE-1:0] id_rs1_addr,
    input  logic [REG_ADDR_SIZE-1:0] id_rs2_addr,
    input  logic                     id_rs1_used,
    input  logic                     id_rs2_used,
    input  logic [REG_ADDR_SIZE-1:0] id_rd_addr,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     flush,
    output logic                     rs1_exe_hazard,
    output logic                     rs1_mem_hazard,
    output logic                     rs2_exe_hazard,
    output logic                     rs2_mem_hazard,
    output logic                     stall
);
    pipe_slot_t exe_q, exe_d, mem_q;
    logic rs1_exe_q, rs1_mem_q, rs2_exe_q, rs2_mem_q;
    logic rs1_exe_d, rs1_mem_d, rs2_exe_d, rs2_mem_d;
    logic m1_exe, m2_exe, m1_mem, m2_mem, adv;

    hazard_addr_cmp u_rs1_exe (.rs_i(id_rs1_addr), .used_i(id_rs1_used), .slot_i(exe_q), .match_o(m1_exe));
    hazard_addr_cmp u_rs2_exe (.rs_i(id_rs2_addr), .used_i(id_rs2_used), .slot_i(exe_q), .match_o(m2_exe));
    hazard_addr_cmp u_rs1_mem (.rs_i(id_rs1_addr), .used_i(id_rs1_used), .slot_i(mem_q), .match_o(m1_mem));
    hazard_addr_cmp u_rs2_mem (.rs_i(id_rs2_addr), .used_i(id_rs2_used), .slot_i(mem_q), .match_o(m2_mem));

    // A load in EXE has no result yet; the consumer waits one cycle and picks it up from MEM.
    assign stall = id_valid & ~flush & exe_q.mem_read & (m1_exe | m2_exe);
    assign adv   = id_valid & ~stall & ~flush;

    always_comb begin
        exe_d     = adv ? '{valid: 1'b1, rd: id_rd_addr, reg_write: id_reg_write, mem_read: id_mem_read}
                        : BUBBLE_SLOT;
        rs1_exe_d = adv & m1_exe & ~exe_q.mem_read;
        rs2_exe_d = adv & m2_exe & ~exe_q.mem_read;
        // The younger (EXE) producer holds the newer value, so it overrides MEM.
        rs1_mem_d = adv & m1_mem & ~rs1_exe_d;
        rs2_mem_d = adv & m2_mem & ~rs2_exe_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q     <= BUBBLE_SLOT;
            mem_q     <= BUBBLE_SLOT;
            rs1_exe_q <= 1'b0;
            rs1_mem_q <= 1'b0;
            rs2_exe_q <= 1'b0;
            rs2_mem_q <= 1'b0;
        end else begin
            exe_q     <= exe_d;
            mem_q     <= exe_q;
            rs1_exe_q <= rs1_exe_d;
            rs1_mem_q <= rs1_mem_d;
            rs2_exe_q <= rs2_exe_d;
            rs2_mem_q <= rs2_mem_d;
        end
    end

    assign rs1_exe_hazard = rs1_exe_q;
    assign rs1_mem_hazard = rs1_mem_q;
    assign rs2_exe_hazard = rs2_exe_q;
    assign rs2_mem_hazard = rs2_mem_q;
endmodule
